cpu_irq_ctrl: RTL
=================

Name: cpu_irq_ctrl

Overview:
- Parametrised successor to the fabric-to-CPU IRQ gating primitive.
- Sits between user-design IRQ nets in the fabric and the external CPU interrupt lines.
- Each channel has a config-selected level/edge mode and polarity, a pending latch with CPU acknowledge, and an overflow flag.
- All outputs are forced inactive until the fabric reports configured.

Parameters:
- NUM_IRQ, 4, number of interrupt channels (1..32).
- NoConfigBits, 8, must equal 2*NUM_IRQ; set manually, no arithmetic parsing.

Ports:
- UserCLK  input  1  fabric user clock; all state is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- IRQ  input  NUM_IRQ  raw interrupt requests from the user design.
- IRQ_ACK_top  input  NUM_IRQ  external, CPU acknowledge; 1-cycle pulse per channel.
- CONFIGURED_top  input  1  external, fabric configuration done.
- IRQ_top  output  NUM_IRQ  external, interrupt lines to the CPU.
- IRQ_OVF_top  output  NUM_IRQ  external, sticky overflow flag per channel.
- ConfigBits  input  NoConfigBits  global config.
  - [2i] = MODE_i: 0 level, 1 edge.
  - [2i+1] = POL_i: 0 active-high/rising, 1 active-low/falling.

Behaviour:
- Reset (rst_n=0, async): cfg_q, hist, pend, ovf, IRQ_top and IRQ_OVF_top all 0.
- cfg_q: CONFIGURED_top registered once. While cfg_q=0:
  - pend, ovf and all outputs are held at 0.
  - hist keeps tracking its input, so configuring never creates a spurious edge.
- Per-channel logic:
  - Normalised sample: n_i = IRQ_i XOR POL_i (the synced version when IRQ_SYNC_EN is defined).
  - hist_i <= n_i every cycle.
- Level mode (MODE_i=0):
  - pend_i <= cfg_q & n_i; IRQ_top_i = pend_i.
  - Latency: 1 UserCLK edge from input change to output.
  - ACK and ovf are ignored; ovf_i held 0.
- Edge mode (MODE_i=1): edge_i = n_i & ~hist_i.
  - edge_i=1 sets pend_i on the next edge. IRQ_top_i = pend_i, so latency is 1 cycle after hist sees the old level.
  - IRQ_ACK_top_i=1 with pend_i=1 clears pend_i next edge.
  - Simultaneous edge and ACK: pend_i stays 1, and the new event is not lost.
  - Edge while pend_i=1 and no ACK: ovf_i is set (sticky). It clears only when an ACK arrives with no coincident edge.
  - ACK with pend_i=0: no effect.
- MODE change at runtime: pend_i and ovf_i are cleared the cycle after the change (mode_q register per channel).
- CONFIGURED_top falling mid-operation: next edge cfg_q=0, so every pend/ovf clears and outputs go to 0 one cycle later.
- IRQ_OVF_top = ovf registered, combinationally gated by cfg_q.

Optional Feature:
- CPU_IRQ_SYNC_EN defined:
  - 2-flop synchroniser on each IRQ bit ahead of the polarity XOR.
  - Adds 2 cycles of latency.
  - Synchroniser flops reset to 0.
- Not defined: IRQ is used directly and is assumed synchronous to UserCLK.

Decomposition:
- Package cpu_irq_pkg:
  - Constants MODE_LEVEL=1'b0, MODE_EDGE=1'b1, POL_HIGH=1'b0, POL_LOW=1'b1.
  - Field offsets CFG_MODE_OFS=0, CFG_POL_OFS=1, CFG_BITS_PER_CH=2.
- Sub-module cpu_irq_channel:
  - One channel: optional sync, hist, pend, ovf, mode_q.
  - Instantiated NUM_IRQ times in a generate loop.
  - The top holds only cfg_q and the ConfigBits slicing.

Test Plan:
- Not configured: CONFIGURED_top=0, IRQ=4'hF, ConfigBits=0 -> IRQ_top=0, IRQ_OVF_top=0 indefinitely. Assert CONFIGURED_top -> IRQ_top=4'hF two edges later.
- Level, POL_LOW on ch1: IRQ[1]=0 -> IRQ_top[1]=1 after 1 cycle (cfg_q already 1). IRQ[1]=1 -> IRQ_top[1]=0 after 1 cycle. IRQ_ACK_top[1] has no effect.
- Edge rising on ch0: 0->1 pulse -> IRQ_top[0]=1 and held after IRQ drops. ACK pulse -> IRQ_top[0]=0 next cycle.
- Overflow on ch2: two rising edges with no ACK -> IRQ_OVF_top[2]=1. ACK coincident with a third edge -> pend stays 1, ovf stays 1. Clean ACK -> both 0.
- Reset mid-operation: pend=4'hF, drop rst_n asynchronously -> IRQ_top=0 immediately. Release with IRQ steady high in edge mode -> no new pend.
- With CPU_IRQ_SYNC_EN: edge-mode rising input -> IRQ_top asserts 3 cycles after the input change instead of 1.

Source files
------------

// File: rtl/cpu_irq_pkg.sv
// Shared constants for the fabric-to-CPU interrupt controller.
// Optional input synchroniser: define CPU_IRQ_SYNC_EN.
package cpu_irq_pkg;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;
    localparam logic POL_HIGH   = 1'b0;
    localparam logic POL_LOW    = 1'b1;

    localparam int unsigned CFG_MODE_OFS    = 0;
    localparam int unsigned CFG_POL_OFS     = 1;
    localparam int unsigned CFG_BITS_PER_CH = 2;

endpackage

// File: rtl/cpu_irq_channel.sv
// One interrupt channel: optional input sync, edge history, pending latch and overflow flag.
// Macro CPU_IRQ_SYNC_EN adds a 2-flop synchroniser on the raw request.
module cpu_irq_channel
    import cpu_irq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic cfg_en,
    input  logic mode,
    input  logic pol,
    input  logic irq,
    input  logic ack,
    output logic pend,
    output logic ovf
);

    logic irq_s;
    logic n;
    logic rise;
    logic hist_q, hist_d;
    logic pend_q, pend_d;
    logic ovf_q, ovf_d;
    logic mode_q, mode_d;

`ifdef CPU_IRQ_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], irq};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign irq_s = sync_q[1];
`else
    assign irq_s = irq;
`endif

    // Normalise polarity so everything downstream is active-high / rising.
    always_comb begin
        n      = (pol == POL_LOW) ? ~irq_s : irq_s;
        rise   = n & ~hist_q;
        hist_d = n;
        mode_d = mode;
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (!cfg_en || (mode != mode_q)) begin
            pend_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (mode == MODE_LEVEL) begin
            pend_d = n;
            ovf_d  = 1'b0;
        end else if (mode == MODE_EDGE) begin
            // A new event wins over a coincident ACK so it is never dropped.
            if (rise) begin
                pend_d = 1'b1;
                if (pend_q && !ack) begin
                    ovf_d = 1'b1;
                end
            end else if (pend_q && ack) begin
                pend_d = 1'b0;
                ovf_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            mode_q <= MODE_LEVEL;
        end else begin
            hist_q <= hist_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            mode_q <= mode_d;
        end
    end

    assign pend = pend_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/cpu_irq_ctrl.sv
// Fabric-to-CPU interrupt controller: configured gate plus NUM_IRQ channels.
// Macro CPU_IRQ_SYNC_EN enables per-channel input synchronisers.
module cpu_irq_ctrl
    import cpu_irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ      = 4,
    parameter int unsigned NoConfigBits = 8
) (
    input  logic                    UserCLK,
    input  logic                    rst_n,
    input  logic [NUM_IRQ-1:0]      IRQ,
    input  logic [NUM_IRQ-1:0]      IRQ_ACK_top,
    input  logic                    CONFIGURED_top,
    output logic [NUM_IRQ-1:0]      IRQ_top,
    output logic [NUM_IRQ-1:0]      IRQ_OVF_top,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    logic               cfg_q, cfg_d;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] ovf;

    always_comb begin
        cfg_d = CONFIGURED_top;
    end

    always_ff @(posedge UserCLK or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
        cpu_irq_channel u_ch (
            .clk    (UserCLK),
            .rst_n  (rst_n),
            .cfg_en (cfg_q),
            .mode   (ConfigBits[CFG_BITS_PER_CH*i + CFG_MODE_OFS]),
            .pol    (ConfigBits[CFG_BITS_PER_CH*i + CFG_POL_OFS]),
            .irq    (IRQ[i]),
            .ack    (IRQ_ACK_top[i]),
            .pend   (pend[i]),
            .ovf    (ovf[i])
        );
    end

    // Overflow flags drop as soon as the fabric leaves the configured state.
    assign IRQ_top     = pend;
    assign IRQ_OVF_top = ovf & {NUM_IRQ{cfg_q}};

endmodule
